// File: rtl/comparador_serial.sv
// Bit-serial magnitude comparator: one comparison cell iterated over a
// loaded operand pair, one bit per clock, producing a done pulse plus
// one-hot gt/eq/lt flags and the number of bits examined.
module comparador_serial #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       busy,
    output logic                       done,
    output logic                       gt,
    output logic                       eq,
    output logic                       lt,
    output logic [$clog2(WIDTH+1)-1:0] nbits
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            p_q, p_d, q_q, q_d;
    logic            gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [CW-1:0]   nbits_q, nbits_d;

    logic            accept;
    logic            bit_a, bit_b, sign_pos;
    logic            p_step, q_step, stop;
    logic [WIDTH-1:0] a_sh, b_sh;

    // Start is only honoured when no comparison is in flight.
    assign accept = start && (state_q == IDLE || state_q == DONE);

    // Pick the bit pair under examination and the shifted operands for the next bit.
    always_comb begin
        if (MSB_FIRST != 0) begin
            bit_a    = a_q[WIDTH-1];
            bit_b    = b_q[WIDTH-1];
            sign_pos = (cnt_q == '0);
            a_sh     = {a_q[WIDTH-2:0], 1'b0};
            b_sh     = {b_q[WIDTH-2:0], 1'b0};
        end else begin
            bit_a    = a_q[0];
            bit_b    = b_q[0];
            sign_pos = (cnt_q == LAST);
            a_sh     = {1'b0, a_q[WIDTH-1:1]};
            b_sh     = {1'b0, b_q[WIDTH-1:1]};
        end
    end

    // Comparison cell: MSB-first latches the first difference, LSB-first lets
    // later (more significant) differences override; the sign bit flips the sense.
    always_comb begin
        p_step = p_q;
        q_step = q_q;
        if ((bit_a != bit_b) && (MSB_FIRST == 0 || !p_q)) begin
            p_step = 1'b1;
            q_step = (SIGNED != 0 && sign_pos) ? bit_b : bit_a;
        end
        // With early exit a RUN cycle never starts with p set, so p_step marks the first difference.
        stop = (cnt_q == LAST) || (EARLY_EXIT != 0 && MSB_FIRST != 0 && p_step);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: DONE always lasts a single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next-state: load on accept, step one bit per RUN cycle, publish flags on exit.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        nbits_d = nbits_q;
        if (accept) begin
            a_d     = a_in;
            b_d     = b_in;
            cnt_d   = '0;
            p_d     = 1'b0;
            q_d     = 1'b1;
            gt_d    = 1'b0;
            eq_d    = 1'b0;
            lt_d    = 1'b0;
            nbits_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_sh;
            b_d   = b_sh;
            cnt_d = cnt_q + ONE;
            p_d   = p_step;
            q_d   = q_step;
            if (stop) begin
                eq_d    = ~p_step;
                gt_d    = p_step & q_step;
                lt_d    = p_step & ~q_step;
                nbits_d = cnt_q + ONE;
            end
        end
    end

    // Datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            p_q     <= 1'b0;
            q_q     <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            nbits_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            nbits_q <= nbits_d;
        end
    end

    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign nbits = nbits_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Testbench for comparador_serial: all eight MSB_FIRST/SIGNED/EARLY_EXIT
// variants run side by side on shared stimulus, checked against an
// arithmetic reference of the comparison and its latency.
module tb_comparador_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;

    logic [7:0]   busy_w, done_w, gt_w, eq_w, lt_w;
    logic [3:0]   nbits_w [8];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    // Instance g: g[2]=MSB_FIRST, g[1]=SIGNED, g[0]=EARLY_EXIT
    for (genvar g = 0; g < 8; g++) begin : g_dut
        comparador_serial #(
            .WIDTH(W), .MSB_FIRST((g >> 2) & 1), .SIGNED((g >> 1) & 1), .EARLY_EXIT(g & 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .a_in(a), .b_in(b),
            .busy(busy_w[g]), .done(done_w[g]), .gt(gt_w[g]), .eq(eq_w[g]),
            .lt(lt_w[g]), .nbits(nbits_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: +1 if A>B, 0 if equal, -1 if A<B
    function automatic int ref_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sgn);
        int ai, bi;
        ai = sgn ? int'($signed(av)) : int'(av);
        bi = sgn ? int'($signed(bv)) : int'(bv);
        if (ai > bi) return 1;
        if (ai < bi) return -1;
        return 0;
    endfunction

    // Reference latency / bits examined
    function automatic int ref_lat(input logic [W-1:0] av, input logic [W-1:0] bv, input int idx);
        if (((idx >> 2) & 1) == 1 && (idx & 1) == 1) begin
            for (int k = 0; k < W; k++)
                if (av[W-1-k] != bv[W-1-k]) return k + 1;
        end
        return W;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int lat);
        lat = -1;
        for (int t = 1; t <= W + 2; t++) begin
            @(posedge clk);
            #1;
            if (done_w[idx]) begin
                lat = t;
                break;
            end
        end
    endtask

    task automatic run_dir(input string tag, input int idx, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input int lat, input logic eg,
                           input logic ee, input logic el);
        int obs;
        idle(12);
        accept(av, bv);
        wait_done(idx, obs);
        chk({tag, "_lat"}, obs, lat);
        chk({tag, "_gt"}, gt_w[idx], eg);
        chk({tag, "_eq"}, eq_w[idx], ee);
        chk({tag, "_lt"}, lt_w[idx], el);
        chk({tag, "_nbits"}, nbits_w[idx], lat);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done_w[idx], 0);
        chk({tag, "_hold"}, {gt_w[idx], eq_w[idx], lt_w[idx]}, {eg, ee, el});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_w, 0);
        chk({tag, "_done"}, done_w, 0);
        chk({tag, "_flags"}, gt_w | eq_w | lt_w, 0);
        for (int i = 0; i < 8; i++) chk({tag, "_nbits"}, nbits_w[i], 0);
    endtask

    initial begin
        int obs;
        int seen [8];
        int seen_t [8];
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Equal operands, MSB-first, full scan
        run_dir("eq5a", 4, 8'h5A, 8'h5A, 8, 1'b0, 1'b1, 1'b0);
        // Early exit on the MSB, unsigned and signed
        run_dir("early_u", 5, 8'h80, 8'h7F, 1, 1'b1, 1'b0, 1'b0);
        run_dir("early_s", 7, 8'h80, 8'h7F, 1, 1'b0, 1'b0, 1'b1);
        // LSB-first scans
        run_dir("lsb_u", 0, 8'h01, 8'h02, 8, 1'b0, 1'b0, 1'b1);
        run_dir("lsb_s", 2, 8'hFF, 8'h01, 8, 1'b0, 1'b0, 1'b1);

        // Start pulses during RUN are ignored
        idle(12);
        accept(8'h10, 8'h20);
        obs = -1;
        for (int t = 1; t <= W + 2; t++) begin
            if (t == 1 || t == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done_w[4]) begin
                obs = t;
                break;
            end
        end
        chk("ign_lat", obs, 8);
        chk("ign_flags", {gt_w[4], eq_w[4], lt_w[4]}, 3'b001);
        // Back-to-back restart from DONE
        accept(8'd3, 8'd9);
        chk("b2b_busy", busy_w[4], 1);
        chk("b2b_done", done_w[4], 0);
        wait_done(4, obs);
        chk("b2b_lat", obs, 8);
        chk("b2b_flags", {gt_w[4], eq_w[4], lt_w[4]}, 3'b001);

        // Asynchronous reset in the middle of a RUN
        idle(12);
        accept(8'h55, 8'hAA);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_dir("post_rst", 4, 8'hC0, 8'h3F, 8, 1'b1, 1'b0, 1'b0);
        run_dir("post_rst_e", 5, 8'hC0, 8'h3F, 1, 1'b1, 1'b0, 1'b0);

        // Random pairs across all eight variants
        idle(12);
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) begin
                seen[i] = 0;
                seen_t[i] = 0;
            end
            accept(ra, rb);
            for (int t = 1; t <= W + 1; t++) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++) begin
                    if (done_w[i]) begin
                        int c;
                        int el;
                        c  = ref_cmp(ra, rb, ((i >> 1) & 1) == 1);
                        el = ref_lat(ra, rb, i);
                        chk("rnd_once", seen[i], 0);
                        chk("rnd_lat", t, el);
                        chk("rnd_flags", {gt_w[i], eq_w[i], lt_w[i]},
                            {c == 1, c == 0, c == -1});
                        chk("rnd_nbits", nbits_w[i], el);
                        seen[i] = 1;
                        seen_t[i] = t;
                    end
                end
            end
            for (int i = 0; i < 8; i++) chk("rnd_seen", seen[i], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
